// File: rtl/abr_prim_sec_anchor_reg_if.sv
// Control/status bundle of the hardened anchor register.
// The master drives write/scrub/clear requests and the slave returns the value and alerts.
interface abr_prim_sec_anchor_reg_if #(
   parameter int unsigned Width = 32
) ();
   logic             we_i;
   logic [Width-1:0] wdata_i;
   logic             scrub_req_i;
   logic             err_clr_i;
   logic [Width-1:0] q_o;
   logic             corr_err_o;
   logic             fatal_err_o;

   modport master (
      output we_i, wdata_i, scrub_req_i, err_clr_i,
      input  q_o, corr_err_o, fatal_err_o
   );

   modport slave (
      input  we_i, wdata_i, scrub_req_i, err_clr_i,
      output q_o, corr_err_o, fatal_err_o
   );
endinterface

// File: rtl/abr_prim_sec_anchor_reg.sv
// Redundant, alternately inverted state register with per-cycle compare.
// Triple copies are repaired by majority scrub; persistent or uncorrectable faults raise a sticky alert.
module abr_prim_sec_anchor_reg #(
   parameter int unsigned      Width       = 32,
   parameter int unsigned      Copies      = 3,
   parameter logic [Width-1:0] ResetValue  = '0,
   parameter int unsigned      ScrubPeriod = 16
) (
   input logic                       clk_i,
   input logic                       rst_i,
   abr_prim_sec_anchor_reg_if.slave  bus
);
   if ((Copies != 2) && (Copies != 3)) begin : gen_bad_copies
      $error("abr_prim_sec_anchor_reg: Copies must be 2 or 3");
   end
   if (ScrubPeriod == 1) begin : gen_bad_period
      $error("abr_prim_sec_anchor_reg: ScrubPeriod must be 0 or >= 2");
   end

   logic [Width-1:0] dec [Copies];
   logic             load;
   logic [Width-1:0] load_val;
   logic             mismatch;

   // keep stops synthesis from recognising the copies as equivalent and merging them
   for (genvar gi = 0; gi < Copies; gi++) begin : gen_copy
      localparam bit Inv = (gi % 2) == 1;
      (* keep = "true" *) logic [Width-1:0] copy_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            copy_q <= Inv ? ~ResetValue : ResetValue;
         end else if (load) begin
            copy_q <= Inv ? ~load_val : load_val;
         end
      end

      assign dec[gi] = Inv ? ~copy_q : copy_q;
   end

   always_comb begin
      mismatch = 1'b0;
      for (int k = 1; k < Copies; k++) begin
         if (dec[k] != dec[0]) mismatch = 1'b1;
      end
   end

   if (Copies == 3) begin : gen_tmr
      localparam int unsigned CntW = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;

      logic [CntW-1:0]  cnt_q, cnt_d;
      logic             verify_q, verify_d;
      logic             corr_q, corr_d;
      logic             fatal_q, fatal_d;
      logic             period_hit, scrub, repair, set_fatal;
      logic [Width-1:0] maj;

      assign maj        = (dec[0] & dec[1]) | (dec[0] & dec[2]) | (dec[1] & dec[2]);
      assign period_hit = (ScrubPeriod != 0) && (cnt_q == CntW'(ScrubPeriod - 1));

      always_comb begin
         scrub     = bus.scrub_req_i | period_hit;
         repair    = scrub & ~bus.we_i & mismatch;
         // a mismatch that survives the repair one cycle earlier is a stuck fault
         set_fatal = verify_q & ~bus.we_i & mismatch;
         cnt_d     = cnt_q + CntW'(1);
         if ((ScrubPeriod == 0) || scrub) cnt_d = '0;
         load      = bus.we_i | repair;
         load_val  = bus.we_i ? bus.wdata_i : maj;
         corr_d    = repair;
         verify_d  = repair;
         fatal_d   = set_fatal | (fatal_q & ~bus.err_clr_i);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt_q    <= '0;
            verify_q <= 1'b0;
            corr_q   <= 1'b0;
            fatal_q  <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            verify_q <= verify_d;
            corr_q   <= corr_d;
            fatal_q  <= fatal_d;
         end
      end

      assign bus.q_o         = maj;
      assign bus.corr_err_o  = corr_q;
      assign bus.fatal_err_o = fatal_q;
   end else begin : gen_dmr
      logic fatal_q, fatal_d;
      logic unused_scrub_req;

      assign unused_scrub_req = bus.scrub_req_i;

      // without a third copy there is no majority, so any divergence is fatal
      always_comb begin
         load     = bus.we_i;
         load_val = bus.wdata_i;
         fatal_d  = (mismatch & ~bus.we_i) | (fatal_q & ~bus.err_clr_i);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            fatal_q <= 1'b0;
         end else begin
            fatal_q <= fatal_d;
         end
      end

      assign bus.q_o         = dec[0];
      assign bus.corr_err_o  = 1'b0;
      assign bus.fatal_err_o = fatal_q;
   end
endmodule

// File: tb/tb_abr_prim_sec_anchor_reg.sv
// Bench for the hardened anchor register: triple- and dual-copy instances against a behavioural model,
// with single-event upsets and stuck-at faults injected by forcing individual copies.
module tb_abr_prim_sec_anchor_reg;
   localparam int W = 32;
   localparam int P = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   abr_prim_sec_anchor_reg_if #(.Width(W)) bus3 ();
   abr_prim_sec_anchor_reg_if #(.Width(W)) bus2 ();

   abr_prim_sec_anchor_reg #(.Width(W), .Copies(3), .ResetValue('0), .ScrubPeriod(P)) dut3 (
      .clk_i(clk), .rst_i(rst), .bus(bus3)
   );
   abr_prim_sec_anchor_reg #(.Width(W), .Copies(2), .ResetValue('0), .ScrubPeriod(0)) dut2 (
      .clk_i(clk), .rst_i(rst), .bus(bus2)
   );

   int checks   = 0;
   int failures = 0;

   // reference state: decoded value held by every copy, scrub timing, flags
   logic [W-1:0] m3 [3];
   logic [W-1:0] m2 [2];
   int           cnt;
   bit           ver, corr3, f3, f2;
   bit           stuck;
   logic [W-1:0] stuck_dec;
   logic [W-1:0] fv_flip, fv_stuck;

   function automatic logic [W-1:0] vote(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("q3", bus3.q_o, vote(m3[0], m3[1], m3[2]));
      chk("corr3", W'(bus3.corr_err_o), W'(corr3));
      chk("fatal3", W'(bus3.fatal_err_o), W'(f3));
      chk("q2", bus2.q_o, m2[0]);
      chk("corr2", W'(bus2.corr_err_o), '0);
      chk("fatal2", W'(bus2.fatal_err_o), W'(f2));
   endtask

   task automatic model_reset();
      m3 = '{'0, '0, '0};
      m2 = '{'0, '0};
      cnt = 0; ver = 0; corr3 = 0; f3 = 0; f2 = 0;
   endtask

   task automatic cyc(input bit we, input logic [W-1:0] wd, input bit scr, input bit clr);
      logic [W-1:0] maj;
      bit mism3, mism2, scrub, rep, setf3;
      bus3.we_i = we; bus3.wdata_i = wd; bus3.scrub_req_i = scr; bus3.err_clr_i = clr;
      bus2.we_i = we; bus2.wdata_i = wd; bus2.scrub_req_i = scr; bus2.err_clr_i = clr;
      maj   = vote(m3[0], m3[1], m3[2]);
      mism3 = (m3[1] != m3[0]) || (m3[2] != m3[0]);
      mism2 = (m2[1] != m2[0]);
      scrub = scr || (cnt == P - 1);
      rep   = scrub && !we && mism3;
      setf3 = ver && !we && mism3;
      @(posedge clk);
      cnt   = scrub ? 0 : cnt + 1;
      if (we) m3 = '{wd, wd, wd};
      else if (rep) m3 = '{maj, maj, maj};
      if (stuck) m3[1] = stuck_dec;
      corr3 = rep;
      ver   = rep;
      f3    = setf3 ? 1'b1 : (clr ? 1'b0 : f3);
      f2    = (mism2 && !we) ? 1'b1 : (clr ? 1'b0 : f2);
      if (we) m2 = '{wd, wd};
      #1;
      check_all();
   endtask

   // flip decoded bits of one copy; the forced value is retained after release
   task inject3(input int k, input logic [W-1:0] mask);
      m3[k]   = m3[k] ^ mask;
      fv_flip = (k % 2 == 1) ? ~m3[k] : m3[k];
      case (k)
         0: begin force dut3.gen_copy[0].copy_q = fv_flip; release dut3.gen_copy[0].copy_q; end
         1: begin force dut3.gen_copy[1].copy_q = fv_flip; release dut3.gen_copy[1].copy_q; end
         default: begin force dut3.gen_copy[2].copy_q = fv_flip; release dut3.gen_copy[2].copy_q; end
      endcase
   endtask

   task inject2(input int k, input logic [W-1:0] mask);
      m2[k]   = m2[k] ^ mask;
      fv_flip = (k == 1) ? ~m2[k] : m2[k];
      if (k == 0) begin force dut2.gen_copy[0].copy_q = fv_flip; release dut2.gen_copy[0].copy_q; end
      else        begin force dut2.gen_copy[1].copy_q = fv_flip; release dut2.gen_copy[1].copy_q; end
   endtask

   initial begin
      bus3.we_i = 0; bus3.wdata_i = '0; bus3.scrub_req_i = 0; bus3.err_clr_i = 0;
      bus2.we_i = 0; bus2.wdata_i = '0; bus2.scrub_req_i = 0; bus2.err_clr_i = 0;
      stuck = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_copy1", dut3.gen_copy[1].copy_q, 32'hFFFF_FFFF);
      @(negedge clk);
      rst = 1'b0;
      $display("reset released: q3=%h fatal3=%0d", bus3.q_o, bus3.fatal_err_o);

      // cycles 0..2 idle, write in cycle 3
      repeat (3) cyc(0, '0, 0, 0);
      cyc(1, 32'hA5A5_5A5A, 0, 0);
      chk("wr_q", bus3.q_o, 32'hA5A5_5A5A);
      chk("wr_copy1", dut3.gen_copy[1].copy_q, 32'h5A5A_A5A5);
      $display("write A5A55A5A: q3=%h copy1=%h", bus3.q_o, dut3.gen_copy[1].copy_q);
      cyc(0, '0, 0, 0);

      // cycle 5: upset bit 7 of copy 2; periodic scrub at cycle 15 repairs it
      inject3(2, 32'h0000_0080);
      #1;
      chk("seu_q", bus3.q_o, 32'hA5A5_5A5A);
      repeat (11) cyc(0, '0, 0, 0);
      chk("scrub_corr_c16", W'(bus3.corr_err_o), W'(1));
      chk("scrub_copy2", dut3.gen_copy[2].copy_q, 32'hA5A5_5A5A);
      $display("periodic scrub: corr3=%0d fatal3=%0d", bus3.corr_err_o, bus3.fatal_err_o);
      cyc(0, '0, 0, 0);
      chk("scrub_corr_c17", W'(bus3.corr_err_o), W'(0));

      // stuck-at on copy 1 bit 0: repair, then fatal on the verify cycle
      cyc(1, 32'h1234_5678, 0, 0);
      m3[1]     = m3[1] ^ 32'h1;
      stuck_dec = m3[1];
      fv_stuck  = ~stuck_dec;
      stuck     = 1;
      force dut3.gen_copy[1].copy_q = fv_stuck;
      cyc(0, '0, 1, 0);
      chk("stuck_corr", W'(bus3.corr_err_o), W'(1));
      cyc(0, '0, 0, 0);
      chk("stuck_fatal", W'(bus3.fatal_err_o), W'(1));
      cyc(0, '0, 0, 1);
      chk("stuck_clr", W'(bus3.fatal_err_o), W'(0));
      cyc(0, '0, 1, 0);
      cyc(0, '0, 0, 0);
      chk("stuck_refatal", W'(bus3.fatal_err_o), W'(1));
      $display("stuck-at: fatal3=%0d after clear and rescrub", bus3.fatal_err_o);
      release dut3.gen_copy[1].copy_q;
      stuck = 0;
      cyc(1, 32'h0F0F_F0F0, 0, 1);

      // write wins over a scrub with a pending mismatch
      inject3(0, 32'h0000_0200);
      cyc(1, 32'hCAFE_BABE, 1, 0);
      chk("wp_copy0", dut3.gen_copy[0].copy_q, 32'hCAFE_BABE);
      chk("wp_copy1", dut3.gen_copy[1].copy_q, ~32'hCAFE_BABE);
      chk("wp_copy2", dut3.gen_copy[2].copy_q, 32'hCAFE_BABE);
      chk("wp_cnt", W'(dut3.gen_tmr.cnt_q), '0);
      $display("write priority: q3=%h corr3=%0d", bus3.q_o, bus3.corr_err_o);

      // dual copies: divergence is fatal at the next edge, never corrected
      inject2(1, 32'h0000_0008);
      cyc(0, '0, 0, 0);
      chk("dmr_fatal", W'(bus2.fatal_err_o), W'(1));
      chk("dmr_q", bus2.q_o, 32'hCAFE_BABE);
      $display("dual copy: fatal2=%0d q2=%h", bus2.fatal_err_o, bus2.q_o);
      cyc(1, 32'h0000_0001, 0, 1);

      // asynchronous reset during the corr_err cycle
      inject3(2, 32'h0000_0010);
      cyc(0, '0, 1, 0);
      chk("ar_corr_pre", W'(bus3.corr_err_o), W'(1));
      #2 rst = 1'b1;
      #1;
      chk("ar_q", bus3.q_o, '0);
      chk("ar_corr", W'(bus3.corr_err_o), '0);
      chk("ar_fatal", W'(bus3.fatal_err_o), '0);
      chk("ar_cnt", W'(dut3.gen_tmr.cnt_q), '0);
      $display("async reset: q3=%h corr3=%0d", bus3.q_o, bus3.corr_err_o);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cyc(0, '0, 0, 0);

      // randomised traffic with occasional upsets on both instances
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 3) == 0) inject3(int'($urandom_range(0, 2)), W'(1) << $urandom_range(0, W - 1));
         if ($urandom_range(0, 7) == 0) inject2(int'($urandom_range(0, 1)), W'(1) << $urandom_range(0, W - 1));
         cyc($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0);
         $display("rand %0d: q3=%h corr3=%0d fatal3=%0d fatal2=%0d", n, bus3.q_o,
                  bus3.corr_err_o, bus3.fatal_err_o, bus2.fatal_err_o);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
